dm_wb_stage: RTL
================

Name: dm_wb_stage

Overview:
Memory-access and MEM/WB pipeline stage of the five-stage MIPS core. It consumes the outputs of the EX/MEM register: IR, PC+8, ALU result, store data, destination register, result-source code and the movz condition. It owns the word-addressed data memory and registers everything into the W stage. It also produces the final register-file write port: address, data and enable. After reset it runs a clear sweep of the memory and holds the pipeline with a busy output until the sweep is done.

Parameters:
DM_WORDS, 1024, data-memory depth in 32-bit words; index taken from AO_M[log2(DM_WORDS)+1:2], upper address bits ignored (aliasing wrap)
PC8_RST, 32'h00003010, reset value of PC8_W

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
IR_M  in  32  instruction in M stage
PC8_M  in  32  PC+8 of that instruction
AO_M  in  32  ALU result / memory byte address
V2_M  in  32  store data (rt, already forwarded)
RFA3M  in  5  destination register
Res_M  in  2  result source: 00 NW, 01 ALU, 10 DM, 11 PC
MemWrite_M  in  1  store enable
movzres_M  in  1  movz condition (rt==0)
dm_busy  out  1  clear sweep in progress; upstream must stall
align_err  out  1  sticky: misaligned access seen
IR_W, PC8_W, AO_W, DR_W  out  32 each  W-stage registers (DR_W = loaded word)
RFA3W  out  5  W-stage destination
Res_W  out  2  W-stage result source
movzres_W  out  1  W-stage movz condition
RegWrite_W  out  1  register-file write enable (combinational from W regs)
WD_W  out  32  register-file write data (combinational from W regs)

Behaviour:
- Reset (async, reset==0):
  - W regs: IR_W=0, AO_W=0, DR_W=0, RFA3W=0, Res_W=00, movzres_W=0, PC8_W=PC8_RST.
  - align_err=0.
  - FSM enters CLEAR with clear pointer=0.
  - Memory contents untouched by reset itself.
- FSM states:
  - CLEAR: each cycle write 0 to word[ptr], ptr++. dm_busy=1. At ptr==DM_WORDS-1, move to RUN on the next edge; sweep takes exactly DM_WORDS cycles.
  - RUN: dm_busy=0. Stays in RUN until reset.
  - Reset asserted mid-sweep restarts the sweep from 0.
- While busy:
  - Stores are ignored.
  - W regs load a bubble each edge (all zero, PC8_W=PC8_RST).
- RUN store: MemWrite_M=1 and AO_M[1:0]==0 -> word[idx]<=V2_M at the edge. Sim-only $display "@%h: *%h <= %h" with PC8_M-8, AO_M, V2_M.
- Loads:
  - Asynchronous read of word[idx], registered into DR_W at the edge; latency 1 cycle to W.
  - Store at edge N followed by a load of the same word in cycle N+1 returns the new data.
  - Store and load can never coincide in one instruction.
- Misaligned access (AO_M[1:0]!=0):
  - With MemWrite_M=1: store suppressed.
  - With Res_M==DM: DR_W<=0.
  - Either case sets align_err, which holds until reset.
- RUN, all other W regs: load the M inputs unchanged every edge; no stall input (the M stage never stalls).
- WD_W by Res_W: 01->AO_W, 10->DR_W, 11->PC8_W, 00->0.
- RegWrite_W = (Res_W!=00) && (RFA3W!=0) && (!isMovz(IR_W) || movzres_W).
  - isMovz means op==0 and func==6'b001010.
  - A movz with movzres_W=0 does not write.

Decomposition:
- Shared package: result-source codes (NW/ALU/DM/PC), opcode/func field ranges and the movz func constant, FSM state encoding (CLEAR, RUN).
- One sub-module: dm_ram. It holds the array, async read and sync write, and takes we/addr/wdata from this block's mux: sweep port when CLEAR, M-stage store when RUN.

Test Plan:
- Reset low 3 cycles, release -> dm_busy=1 for exactly 1024 cycles, then 0; W regs stay bubble (PC8_W=00003010) throughout.
- RUN: sw AO_M=0x10, V2_M=0xDEADBEEF, then lw AO_M=0x10, Res_M=10, RFA3M=8 -> next cycle DR_W=0xDEADBEEF, WD_W=0xDEADBEEF, RegWrite_W=1, RFA3W=8.
- Address alias: sw AO_M=0x1004 data 0x55, lw AO_M=0x4 -> DR_W=0x55.
- Misaligned: sw AO_M=0x22 data 0x1 -> word[8] unchanged (a later lw 0x20 gives its earlier value); align_err=1 and stays 1.
- movz with movzres_M=0, RFA3M=3, Res_M=01 -> RegWrite_W=0. With movzres_M=1 -> RegWrite_W=1, WD_W=AO_W. jal with Res_M=11, RFA3M=31, PC8_M=0x3008 -> WD_W=0x3008. Res_M=01 with RFA3M=0 -> RegWrite_W=0.
- Reset pulsed mid-sweep at cycle 500 -> sweep restarts: dm_busy high a further 1024 cycles after release; a word previously stored reads 0 afterwards.

Source files
------------

// File: rtl/dm_wb_stage_pkg.sv
// Shared definitions for the memory-access / MEM-WB stage.
//   - result-source codes carried on Res_M / Res_W
//   - instruction field ranges and the movz function code
//   - clear-sweep FSM state encoding
//   - is_movz() helper used to qualify the register-file write enable
package dm_wb_stage_pkg;

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC  = 2'b11
  } res_src_e;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNC_MOVZ  = 6'b001010;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  function automatic logic is_movz(input logic [31:0] ir);
    return (ir[OP_MSB:OP_LSB] == OP_SPECIAL) && (ir[FUNC_MSB:FUNC_LSB] == FUNC_MOVZ);
  endfunction

endpackage

// File: rtl/dm_wb_stage_if.sv
// Bundle of the M-stage inputs and W-stage outputs of dm_wb_stage.
//   slave  : the stage itself (consumes *_M, produces *_W, dm_busy, align_err)
//   master : the surrounding pipeline / testbench
interface dm_wb_stage_if;
  logic [31:0] IR_M, PC8_M, AO_M, V2_M;
  logic [4:0]  RFA3M;
  logic [1:0]  Res_M;
  logic        MemWrite_M, movzres_M;

  logic        dm_busy, align_err;
  logic [31:0] IR_W, PC8_W, AO_W, DR_W;
  logic [4:0]  RFA3W;
  logic [1:0]  Res_W;
  logic        movzres_W;
  logic        RegWrite_W;
  logic [31:0] WD_W;

  modport slave (
    input  IR_M, PC8_M, AO_M, V2_M, RFA3M, Res_M, MemWrite_M, movzres_M,
    output dm_busy, align_err, IR_W, PC8_W, AO_W, DR_W, RFA3W, Res_W,
           movzres_W, RegWrite_W, WD_W
  );

  modport master (
    output IR_M, PC8_M, AO_M, V2_M, RFA3M, Res_M, MemWrite_M, movzres_M,
    input  dm_busy, align_err, IR_W, PC8_W, AO_W, DR_W, RFA3W, Res_W,
           movzres_W, RegWrite_W, WD_W
  );
endinterface

// File: rtl/dm_wb_stage_dm_ram.sv
// Word-addressed data memory: one synchronous write port, asynchronous read.
// No reset; contents are cleared by the owning stage's sweep.
//   clk      in  clock
//   we_i     in  write enable
//   addr_i   in  word index (shared by read and write)
//   wdata_i  in  write data
//   rdata_o  out combinational read of word[addr_i]
module dm_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/dm_wb_stage.sv
// Memory-access and MEM/WB pipeline stage.
// Owns the data memory, registers the M-stage bundle into W, and forms the
// register-file write port. After reset it zeroes the whole memory, one word
// per cycle, holding dm_busy high and loading bubbles into W meanwhile.
//   clk    in  clock, all state on rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of dm_wb_stage_if (M inputs, W outputs)
module dm_wb_stage
  import dm_wb_stage_pkg::*;
#(
  parameter int          DM_WORDS = 1024,
  parameter logic [31:0] PC8_RST  = 32'h0000_3010
) (
  input logic           clk,
  input logic           reset,
  dm_wb_stage_if.slave  bus
);
  localparam int AW = $clog2(DM_WORDS);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          align_q, align_d;

  logic [31:0] ir_q, pc8_q, ao_q, dr_q;
  logic [4:0]  rfa3_q;
  logic [1:0]  res_q;
  logic        movz_q;

  logic          running, misaligned, is_load, bad_access;
  logic [AW-1:0] idx;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  assign running    = (state_q == ST_RUN);
  // Upper address bits are ignored, so addresses alias modulo the memory size.
  assign idx        = bus.AO_M[AW+1:2];
  assign misaligned = (bus.AO_M[1:0] != 2'b00);
  assign is_load    = (bus.Res_M == RES_DM);
  assign bad_access = misaligned && (bus.MemWrite_M || is_load);

  // Sweep owns the write port while clearing; the M-stage store owns it after.
  always_comb begin
    ram_we    = 1'b1;
    ram_addr  = ptr_q;
    ram_wdata = 32'h0;
    if (running) begin
      ram_we    = bus.MemWrite_M && !misaligned;
      ram_addr  = idx;
      ram_wdata = bus.V2_M;
    end
  end

  dm_ram #(.WORDS(DM_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    align_d = align_q;
    if (!running) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AW'(DM_WORDS - 1)) state_d = ST_RUN;
    end else if (bad_access) begin
      align_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      align_q <= 1'b0;
      ir_q    <= 32'h0;
      pc8_q   <= PC8_RST;
      ao_q    <= 32'h0;
      dr_q    <= 32'h0;
      rfa3_q  <= 5'd0;
      res_q   <= RES_NW;
      movz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      align_q <= align_d;
      if (running) begin
        ir_q   <= bus.IR_M;
        pc8_q  <= bus.PC8_M;
        ao_q   <= bus.AO_M;
        // A misaligned load returns zero rather than the containing word.
        dr_q   <= (misaligned && is_load) ? 32'h0 : ram_rdata;
        rfa3_q <= bus.RFA3M;
        res_q  <= bus.Res_M;
        movz_q <= bus.movzres_M;
      end else begin
        ir_q   <= 32'h0;
        pc8_q  <= PC8_RST;
        ao_q   <= 32'h0;
        dr_q   <= 32'h0;
        rfa3_q <= 5'd0;
        res_q  <= RES_NW;
        movz_q <= 1'b0;
      end
    end
  end

  assign bus.dm_busy   = !running;
  assign bus.align_err = align_q;
  assign bus.IR_W      = ir_q;
  assign bus.PC8_W     = pc8_q;
  assign bus.AO_W      = ao_q;
  assign bus.DR_W      = dr_q;
  assign bus.RFA3W     = rfa3_q;
  assign bus.Res_W     = res_q;
  assign bus.movzres_W = movz_q;

  always_comb begin
    bus.WD_W = 32'h0;
    case (res_q)
      RES_ALU: bus.WD_W = ao_q;
      RES_DM:  bus.WD_W = dr_q;
      RES_PC:  bus.WD_W = pc8_q;
      default: bus.WD_W = 32'h0;
    endcase
  end

  // A movz whose rt was non-zero is a no-op for the register file.
  assign bus.RegWrite_W = (res_q != RES_NW) && (rfa3_q != 5'd0) &&
                          (!is_movz(ir_q) || movz_q);
endmodule
